// File: rtl/vp_pkg.sv
// Shared constants for the vector_product block.
//   MODE_CROSS / MODE_DOT : encoding of the in_mode / out_mode sideband bit
//   VP_DATA_W / VP_TAG_W  : default operand and tag widths
//   VP_STAGES             : pipeline depth (S1 products, S2 sums, S3 round/sat)
package vp_pkg;
  localparam int   VP_DATA_W  = 24;
  localparam int   VP_TAG_W   = 8;
  localparam logic MODE_CROSS = 1'b0;
  localparam logic MODE_DOT   = 1'b1;
  localparam int   VP_STAGES  = 3;
  localparam int   VP_NPROD   = 6;   // multipliers in S1
  localparam int   VP_NLANE   = 3;   // result lanes x, y, z
endpackage

// File: rtl/vp_round_sat.sv
// Round-half-up and saturate one signed lane.
//   din  : signed IN_W-bit value
//   dout : signed OUT_W-bit value = sat((din + 2^(SHIFT-1)) >>> SHIFT)
// The add is done one bit wider than din so the bias can never wrap.
module vp_round_sat #(
  parameter int IN_W  = 50,
  parameter int SHIFT = 24,
  parameter int OUT_W = 24
) (
  input  logic signed [IN_W-1:0]  din,
  output logic signed [OUT_W-1:0] dout
);
  localparam logic signed [IN_W:0] HALF =
    {{(IN_W+1-SHIFT){1'b0}}, 1'b1, {(SHIFT-1){1'b0}}};
  localparam logic signed [IN_W:0] MAXV =
    {{(IN_W+2-OUT_W){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [IN_W:0] MINV =
    {{(IN_W+2-OUT_W){1'b1}}, {(OUT_W-1){1'b0}}};

  logic signed [IN_W:0] biased;
  logic signed [IN_W:0] shifted;

  always_comb begin
    biased  = {din[IN_W-1], din} + HALF;
    shifted = biased >>> SHIFT;
    if (shifted > MAXV)      dout = MAXV[OUT_W-1:0];
    else if (shifted < MINV) dout = MINV[OUT_W-1:0];
    else                     dout = shifted[OUT_W-1:0];
  end
endmodule

// File: rtl/vector_product.sv
// 3-stage cross / dot product pipeline on 3-element signed vectors.
//   clk, rst_n          : clock, async active-low reset
//   in_valid/in_ready   : input handshake; in_mode 0 = cross, 1 = dot
//   in_tag              : opaque sideband returned with the result
//   ux..vz              : signed 1Q(DATA_W-1) operands
//   out_valid/out_ready : output handshake
//   out_x/y/z           : signed 2Q(DATA_W-2) results, rounded and saturated
//   out_mode, out_tag   : sideband aligned with the result
// The whole pipe advances on a single enable, so a stalled output freezes
// every stage and nothing is dropped or duplicated.
module vector_product
  import vp_pkg::*;
#(
  parameter int DATA_W = VP_DATA_W,
  parameter int TAG_W  = VP_TAG_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_mode,
  input  logic [TAG_W-1:0]         in_tag,
  input  logic signed [DATA_W-1:0] ux,
  input  logic signed [DATA_W-1:0] uy,
  input  logic signed [DATA_W-1:0] uz,
  input  logic signed [DATA_W-1:0] vx,
  input  logic signed [DATA_W-1:0] vy,
  input  logic signed [DATA_W-1:0] vz,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_x,
  output logic signed [DATA_W-1:0] out_y,
  output logic signed [DATA_W-1:0] out_z,
  output logic                     out_mode,
  output logic [TAG_W-1:0]         out_tag
);
  localparam int PW = 2*DATA_W;     // product width
  localparam int SW = 2*DATA_W + 2; // sum width, holds 3 full-scale products

  logic adv;

  logic [VP_STAGES:1]             vld_q, vld_d;
  logic [VP_STAGES:0]             vld_pipe;
  logic [VP_STAGES:1]             mode_q, mode_d;
  logic [VP_STAGES:1][TAG_W-1:0]  tag_q, tag_d;

  logic [VP_NPROD-1:0][DATA_W-1:0] opa, opb;
  logic [VP_NPROD-1:0][PW-1:0]     prod_c, prod_q, prod_d;
  logic [VP_NLANE-1:0][SW-1:0]     sum_c, sum_q, sum_d;
  logic [VP_NLANE-1:0][DATA_W-1:0] rs_c, res_q, res_d;
  logic signed [SW-1:0]            p [VP_NPROD];

  assign vld_pipe  = {vld_q, in_valid};
  assign out_valid = vld_pipe[VP_STAGES];
  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv;

  // Operand steering: cross needs six distinct products, dot only three,
  // so the same six multipliers serve both modes.
  always_comb begin
    opa = '0;
    opb = '0;
    if (in_mode == MODE_DOT) begin
      opa[0] = ux; opb[0] = vx;
      opa[1] = uy; opb[1] = vy;
      opa[2] = uz; opb[2] = vz;
    end else begin
      opa[0] = uy; opb[0] = vz;
      opa[1] = uz; opb[1] = vy;
      opa[2] = uz; opb[2] = vx;
      opa[3] = ux; opb[3] = vz;
      opa[4] = ux; opb[4] = vy;
      opa[5] = uy; opb[5] = vx;
    end
  end

  for (genvar i = 0; i < VP_NPROD; i++) begin : g_mul
    assign prod_c[i] = PW'($signed(opa[i])) * PW'($signed(opb[i]));
  end

  // S2 combine; mode_q[1] travels with the S1 products
  always_comb begin
    for (int i = 0; i < VP_NPROD; i++) p[i] = SW'($signed(prod_q[i]));
    sum_c = '0;
    if (mode_q[1] == MODE_DOT) begin
      sum_c[0] = p[0] + p[1] + p[2];
    end else begin
      sum_c[0] = p[0] - p[1];
      sum_c[1] = p[2] - p[3];
      sum_c[2] = p[4] - p[5];
    end
  end

  for (genvar l = 0; l < VP_NLANE; l++) begin : g_lane
    vp_round_sat #(.IN_W(SW), .SHIFT(DATA_W), .OUT_W(DATA_W)) u_rs (
      .din  ($signed(sum_q[l])),
      .dout (rs_c[l])
    );
  end

  always_comb begin
    vld_d  = vld_q;
    mode_d = mode_q;
    tag_d  = tag_q;
    prod_d = prod_q;
    sum_d  = sum_q;
    res_d  = res_q;
    if (adv) begin
      vld_d  = vld_pipe[VP_STAGES-1:0];
      mode_d = {mode_q[VP_STAGES-1:1], in_mode};
      tag_d  = {tag_q[VP_STAGES-1:1], in_tag};
      prod_d = prod_c;
      sum_d  = sum_c;
      res_d  = rs_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= '0;
      mode_q <= '0;
      tag_q  <= '0;
      prod_q <= '0;
      sum_q  <= '0;
      res_q  <= '0;
    end else begin
      vld_q  <= vld_d;
      mode_q <= mode_d;
      tag_q  <= tag_d;
      prod_q <= prod_d;
      sum_q  <= sum_d;
      res_q  <= res_d;
    end
  end

  assign out_x    = res_q[0];
  assign out_y    = res_q[1];
  assign out_z    = res_q[2];
  assign out_mode = mode_q[VP_STAGES];
  assign out_tag  = tag_q[VP_STAGES];
endmodule

// File: tb/tb_vector_product.sv
// Self-checking bench for vector_product: directed vectors, backpressure,
// mid-flight reset and a randomized stream, with a scoreboard queue.
module tb_vector_product;
  localparam int DW = 24;
  localparam int TW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          in_mode = 1'b0;
  logic [TW-1:0] in_tag = '0;
  logic [DW-1:0] ux = '0, uy = '0, uz = '0, vx = '0, vy = '0, vz = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] out_x, out_y, out_z;
  logic          out_mode;
  logic [TW-1:0] out_tag;

  vector_product #(.DATA_W(DW), .TAG_W(TW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode), .in_tag(in_tag),
    .ux(ux), .uy(uy), .uz(uz), .vx(vx), .vy(vy), .vz(vz),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_x(out_x), .out_y(out_y), .out_z(out_z),
    .out_mode(out_mode), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] x, y, z;
    logic          mode;
    logic [TW-1:0] tag;
  } exp_t;

  exp_t sb[$];
  exp_t drv_exp;
  int   n_chk = 0;
  int   n_fail = 0;
  int   n_pop = 0;
  logic acc = 1'b0;

  function automatic exp_t mk(logic [DW-1:0] x, logic [DW-1:0] y, logic [DW-1:0] z,
                              logic m, logic [TW-1:0] t);
    exp_t e;
    e.x = x; e.y = y; e.z = z; e.mode = m; e.tag = t;
    return e;
  endfunction

  // Reference: exact 64-bit arithmetic, round half up, clamp.
  function automatic exp_t model(logic m, logic [TW-1:0] t,
                                 logic [DW-1:0] a0, logic [DW-1:0] a1, logic [DW-1:0] a2,
                                 logic [DW-1:0] b0, logic [DW-1:0] b1, logic [DW-1:0] b2);
    longint ax = longint'($signed(a0));
    longint ay = longint'($signed(a1));
    longint az = longint'($signed(a2));
    longint bx = longint'($signed(b0));
    longint by = longint'($signed(b1));
    longint bz = longint'($signed(b2));
    longint s [3];
    longint r;
    logic [DW-1:0] v [3];
    if (m) begin
      s[0] = ax*bx + ay*by + az*bz; s[1] = 0; s[2] = 0;
    end else begin
      s[0] = ay*bz - az*by;
      s[1] = az*bx - ax*bz;
      s[2] = ax*by - ay*bx;
    end
    for (int i = 0; i < 3; i++) begin
      r = (s[i] + 64'sd8388608) >>> 24;
      if (r > 64'sd8388607) r = 64'sd8388607;
      else if (r < -64'sd8388608) r = -64'sd8388608;
      v[i] = r[DW-1:0];
    end
    return mk(v[0], v[1], v[2], m, t);
  endfunction

  function automatic logic [DW-1:0] rnd_op();
    logic [31:0] r;
    r = $urandom();
    case ($urandom_range(0, 4))
      0:       return 24'h7FFFFF;
      1:       return 24'h800000;
      2:       return 24'h000000;
      default: return r[DW-1:0];
    endcase
  endfunction

  task automatic set_op(input logic m, input logic [TW-1:0] t,
                        input logic [DW-1:0] a0, input logic [DW-1:0] a1, input logic [DW-1:0] a2,
                        input logic [DW-1:0] b0, input logic [DW-1:0] b1, input logic [DW-1:0] b2,
                        input exp_t ex);
    in_valid = 1'b1; in_mode = m; in_tag = t;
    ux = a0; uy = a1; uz = a2; vx = b0; vy = b1; vz = b2;
    drv_exp = ex;
  endtask

  // One clock: sample the handshakes just before the edge, pop/compare any
  // result leaving, push the expectation of any op entering.
  task automatic step();
    exp_t e;
    #1;
    if (out_valid && out_ready) begin
      n_chk++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: got tag=%h, expected no output", out_tag);
      end else begin
        e = sb.pop_front();
        n_pop++;
        if ({out_x, out_y, out_z, out_mode, out_tag} !== {e.x, e.y, e.z, e.mode, e.tag}) begin
          n_fail++;
          $display("FAIL sb_result: got x=%h y=%h z=%h mode=%b tag=%h, expected x=%h y=%h z=%h mode=%b tag=%h",
                   out_x, out_y, out_z, out_mode, out_tag, e.x, e.y, e.z, e.mode, e.tag);
        end
      end
    end
    acc = in_valid && in_ready;
    if (acc) sb.push_back(drv_exp);
    @(posedge clk);
    @(negedge clk);
  endtask

  // Single op through an otherwise idle pipe with exact latency checks.
  task automatic issue_one(input string name, input logic m, input logic [TW-1:0] t,
                           input logic [DW-1:0] a0, input logic [DW-1:0] a1, input logic [DW-1:0] a2,
                           input logic [DW-1:0] b0, input logic [DW-1:0] b1, input logic [DW-1:0] b2,
                           input exp_t ex);
    out_ready = 1'b1;
    set_op(m, t, a0, a1, a2, b0, b1, b2, ex);
    step();
    in_valid = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      n_chk++;
      if (out_valid !== (k == 3)) begin
        n_fail++;
        $display("FAIL %s_latency: cycle %0d got out_valid=%b, expected %b", name, k, out_valid, (k == 3));
      end
      if (k < 3) step();
    end
    n_chk++;
    if ({out_x, out_y, out_z, out_mode, out_tag} !== {ex.x, ex.y, ex.z, ex.mode, ex.tag}) begin
      n_fail++;
      $display("FAIL %s_value: got x=%h y=%h z=%h mode=%b tag=%h, expected x=%h y=%h z=%h mode=%b tag=%h",
               name, out_x, out_y, out_z, out_mode, out_tag, ex.x, ex.y, ex.z, ex.mode, ex.tag);
    end
    step();
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #1;
    n_chk++;
    if ({out_valid, out_x, out_y, out_z, out_mode, out_tag} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got valid=%b x=%h y=%h z=%h mode=%b tag=%h, expected all zero",
               out_valid, out_x, out_y, out_z, out_mode, out_tag);
    end
    n_chk++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b, expected 1", in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_chk++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL release_in_ready: got %b, expected 1", in_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_cross();
    issue_one("cross", 1'b0, 8'hA5, 24'h400000, 24'h0, 24'h0, 24'h0, 24'h400000, 24'h0,
              mk(24'h0, 24'h0, 24'h100000, 1'b0, 8'hA5));
  endtask

  task automatic test_dot_sat();
    issue_one("dot_pos_sat", 1'b1, 8'h11, 24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF,
              24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF, mk(24'h7FFFFF, 24'h0, 24'h0, 1'b1, 8'h11));
    issue_one("dot_neg_sat", 1'b1, 8'h22, 24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF,
              24'h800000, 24'h800000, 24'h800000, mk(24'h800000, 24'h0, 24'h0, 1'b1, 8'h22));
  endtask

  task automatic test_rounding();
    issue_one("round_below", 1'b0, 8'h31, 24'h0, 24'h000001, 24'h0, 24'h0, 24'h0, 24'h400000,
              mk(24'h0, 24'h0, 24'h0, 1'b0, 8'h31));
    issue_one("round_half", 1'b0, 8'h32, 24'h0, 24'h000002, 24'h0, 24'h0, 24'h0, 24'h400000,
              mk(24'h000001, 24'h0, 24'h0, 1'b0, 8'h32));
  endtask

  task automatic test_back_to_back();
    int issued = 0;
    int pop0 = n_pop;
    logic [DW-1:0] a;
    logic exp_rdy;
    acc = 1'b0;
    in_valid = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      if (!in_valid || acc) begin
        if (issued < 6) begin
          issued++;
          a = DW'(issued * 24'h031000);
          set_op(1'b0, TW'(issued), a, 24'h200000, 24'hF00000, 24'h100000, a, 24'h345678,
                 model(1'b0, TW'(issued), a, 24'h200000, 24'hF00000, 24'h100000, a, 24'h345678));
        end else in_valid = 1'b0;
      end
      out_ready = !(c >= 4 && c <= 8);
      exp_rdy   = !(c >= 4 && c <= 8);
      #1;
      n_chk++;
      if (in_ready !== exp_rdy) begin
        n_fail++;
        $display("FAIL bp_in_ready: cycle %0d got %b, expected %b", c, in_ready, exp_rdy);
      end
      step();
    end
    n_chk++;
    if ((n_pop - pop0) != 6 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL bp_count: got %0d results (%0d pending), expected 6 (0 pending)",
               n_pop - pop0, sb.size());
    end
    out_ready = 1'b1;
  endtask

  task automatic test_reset_midflight();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_op(1'b1, TW'(8'h40 + i), 24'h100000, 24'h0, 24'h0, 24'h100000, 24'h0, 24'h0,
             model(1'b1, TW'(8'h40 + i), 24'h100000, 24'h0, 24'h0, 24'h100000, 24'h0, 24'h0));
      step();
    end
    in_valid = 1'b0;
    n_chk++;
    if (out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_inflight: got out_valid=%b, expected 1", out_valid);
    end
    rst_n = 1'b0;
    #1;
    n_chk++;
    if ({out_valid, out_x, out_y, out_z, out_mode, out_tag} !== '0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_reset: got valid=%b x=%h tag=%h in_ready=%b, expected valid=0 x=0 tag=0 in_ready=1",
               out_valid, out_x, out_tag, in_ready);
    end
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_chk++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_release_ready: got %b, expected 1", in_ready);
    end
    issue_one("post_reset", 1'b0, 8'h77, 24'h0, 24'h200000, 24'h0, 24'h0, 24'h0, 24'h200000,
              mk(24'h040000, 24'h0, 24'h0, 1'b0, 8'h77));
    for (int k = 0; k < 5; k++) begin
      step();
      n_chk++;
      if (out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL post_reset_idle: got out_valid=%b tag=%h, expected 0", out_valid, out_tag);
      end
    end
  endtask

  task automatic test_random();
    int issued = 0;
    logic m;
    logic [DW-1:0] a0, a1, a2, b0, b1, b2;
    int c = 0;
    acc = 1'b0;
    in_valid = 1'b0;
    while (c < 800 && (issued < 40 || in_valid || sb.size() != 0)) begin
      if (!in_valid || acc) begin
        if (issued < 40 && $urandom_range(0, 3) != 0) begin
          m = 1'($urandom_range(0, 1));
          a0 = rnd_op(); a1 = rnd_op(); a2 = rnd_op();
          b0 = rnd_op(); b1 = rnd_op(); b2 = rnd_op();
          set_op(m, TW'(8'h80 + issued), a0, a1, a2, b0, b1, b2,
                 model(m, TW'(8'h80 + issued), a0, a1, a2, b0, b1, b2));
          issued++;
        end else in_valid = 1'b0;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      step();
      c++;
    end
    n_chk++;
    if (sb.size() != 0 || issued != 40) begin
      n_fail++;
      $display("FAIL rand_drain: got %0d issued %0d pending, expected 40 issued 0 pending",
               issued, sb.size());
    end
    out_ready = 1'b1;
    in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_cross();
    test_dot_sat();
    test_rounding();
    test_back_to_back();
    test_reset_midflight();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1);
  end
endmodule
